// File: rtl/t_ff_toggle_rx_pkg.sv
// rtl/t_ff_toggle_rx_pkg.sv - shared state type and default widths for t_ff_toggle_rx
package t_ff_toggle_rx_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } state_t;

  localparam int unsigned CNT_W_DEF  = 8;
  localparam int unsigned PEND_W_DEF = 3;

endpackage

// File: rtl/toggle_edge_det.sv
// rtl/toggle_edge_det.sv - toggle-line edge detector with registered pulse
// Optional 2-flop input synchronizer enabled by T_FF_TOGGLE_RX_SYNC_EN.
module toggle_edge_det (
  input  logic clk_i,
  input  logic clear_i,
  input  logic t_i,
  output logic tog_o,
  output logic pulse_o
);

  logic line;
  logic t_q;
  logic pulse_q;

`ifdef T_FF_TOGGLE_RX_SYNC_EN
  logic s1_q;
  logic s2_q;

  // On clear every stage takes the current line level so nothing in flight counts.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      s1_q <= t_i;
      s2_q <= t_i;
    end else begin
      s1_q <= t_i;
      s2_q <= s1_q;
    end
  end

  assign line = s2_q;
`else
  assign line = t_i;
`endif

  assign tog_o = line ^ t_q;

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      t_q     <= t_i;
      pulse_q <= 1'b0;
    end else begin
      t_q     <= line;
      pulse_q <= tog_o;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/t_ff_toggle_rx.sv
// rtl/t_ff_toggle_rx.sv - toggle-line event receiver with pending buffer and valid/ready release
// Input synchronizer selectable with T_FF_TOGGLE_RX_SYNC_EN (see toggle_edge_det).
module t_ff_toggle_rx
  import t_ff_toggle_rx_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned PEND_W = PEND_W_DEF
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              t_in,
  output logic              pulse_out,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [PEND_W-1:0] pending,
  output logic [CNT_W-1:0]  ev_count,
  output logic              overflow,
  output logic [1:0]        state
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;

  logic              tog;
  logic              accept;
  logic              ovf_set;
  logic [PEND_W-1:0] pending_q;
  logic [PEND_W-1:0] pending_d;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;
  state_t            state_q;

  toggle_edge_det u_det (
    .clk_i   (clk),
    .clear_i (clear),
    .t_i     (t_in),
    .tog_o   (tog),
    .pulse_o (pulse_out)
  );

  assign ev_valid = (pending_q != '0);
  assign accept   = ev_valid && ev_ready;

  // A toggle and an accept in the same cycle cancel, so a full buffer does not overflow.
  always_comb begin
    pending_d = pending_q;
    ovf_set   = 1'b0;
    if (tog && !accept) begin
      if (pending_q != PEND_MAX) begin
        pending_d = pending_q + PEND_ONE;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (!tog && accept) begin
      pending_d = pending_q - PEND_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      pending_q <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      state_q   <= EMPTY;
    end else begin
      pending_q <= pending_d;
      if (accept) begin
        count_q <= count_q + CNT_ONE;
      end
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end
      case (state_q)
        EMPTY: begin
          if (pending_d == PEND_MAX) begin
            state_q <= FULL;
          end else if (pending_d != '0) begin
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (pending_d == PEND_MAX) begin
            state_q <= FULL;
          end else if (pending_d == '0) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (pending_d == '0) begin
            state_q <= EMPTY;
          end else if (pending_d != PEND_MAX) begin
            state_q <= ACTIVE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign pending  = pending_q;
  assign ev_count = count_q;
  assign overflow = ovf_q;
  assign state    = state_q;

endmodule

// File: tb/tb_t_ff_toggle_rx.sv
// tb/tb_t_ff_toggle_rx.sv - directed table plus randomized model check of t_ff_toggle_rx
// Latency of the reference model follows T_FF_TOGGLE_RX_SYNC_EN.
module tb_t_ff_toggle_rx;

  localparam int MAXP = 7;
`ifdef T_FF_TOGGLE_RX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       t_in = 1'b0;
  logic       ev_ready = 1'b0;
  logic       pulse_out, ev_valid, overflow;
  logic [2:0] pending;
  logic [7:0] ev_count;
  logic [1:0] state;
  logic       pulse2, valid2, ovf2;
  logic [2:0] pend2;
  logic [1:0] cnt2;
  logic [1:0] state2;

  t_ff_toggle_rx #(.CNT_W(8), .PEND_W(3)) u_dut (
    .clk(clk), .clear(clear), .t_in(t_in), .pulse_out(pulse_out),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .pending(pending),
    .ev_count(ev_count), .overflow(overflow), .state(state)
  );

  t_ff_toggle_rx #(.CNT_W(2), .PEND_W(3)) u_dut2 (
    .clk(clk), .clear(clear), .t_in(t_in), .pulse_out(pulse2),
    .ev_valid(valid2), .ev_ready(ev_ready), .pending(pend2),
    .ev_count(cnt2), .overflow(ovf2), .state(state2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int   m_pend, m_cnt, m_ovf, m_pulse;
  logic m_last;
  int   dl[$];

  typedef struct {
    logic c, t, r, p;
    int   pend, cnt;
    logic ovf;
    int   st;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Events are edges between successive sampled levels, taking effect LAT-1 edges later.
  task automatic model_step();
    int eff;
    bit acc;
    if (clear) begin
      m_last = t_in;
      dl.delete();
      repeat (LAT - 1) dl.push_back(0);
      m_pend = 0; m_cnt = 0; m_ovf = 0; m_pulse = 0;
    end else begin
      dl.push_back((t_in != m_last) ? 1 : 0);
      m_last = t_in;
      eff = dl.pop_front();
      acc = ev_ready && (m_pend != 0);
      m_pulse = eff;
      if (eff != 0 && !acc) begin
        if (m_pend < MAXP) m_pend++;
        else m_ovf = 1;
      end else if (eff == 0 && acc) begin
        m_pend--;
      end
      if (acc) m_cnt = (m_cnt + 1) % 256;
    end
  endtask

  task automatic check_model();
    int exp_st;
    exp_st = (m_pend == 0) ? 0 : ((m_pend == MAXP) ? 2 : 1);
    chk("m_pulse", pulse_out, m_pulse);
    chk("m_pending", pending, m_pend);
    chk("m_valid", ev_valid, (m_pend != 0));
    chk("m_count", ev_count, m_cnt);
    chk("m_overflow", overflow, m_ovf);
    chk("m_state", state, exp_st);
    chk("m_count2", cnt2, m_cnt % 4);
  endtask

  task automatic step(input logic c, input logic t, input logic r);
    clear = c; t_in = t; ev_ready = r;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  function automatic vec_t mk(input logic c, t, r, p, input int pend, cnt, input logic ovf,
                              input int st);
    vec_t v;
    v.c = c; v.t = t; v.r = r; v.p = p; v.pend = pend; v.cnt = cnt; v.ovf = ovf; v.st = st;
    return v;
  endfunction

  initial begin
    // reset with line high, then hold
    tbl.push_back(mk(1,1,0,0,0,0,0,0)); tbl.push_back(mk(1,1,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0)); tbl.push_back(mk(0,1,0,0,0,0,0,0));
    // three toggles on alternate cycles
    tbl.push_back(mk(0,0,0,1,1,0,0,1)); tbl.push_back(mk(0,0,0,0,1,0,0,1));
    tbl.push_back(mk(0,1,0,1,2,0,0,1)); tbl.push_back(mk(0,1,0,0,2,0,0,1));
    tbl.push_back(mk(0,0,0,1,3,0,0,1)); tbl.push_back(mk(0,0,0,0,3,0,0,1));
    // drain, fourth ready ignored
    tbl.push_back(mk(0,0,1,0,2,1,0,1)); tbl.push_back(mk(0,0,1,0,1,2,0,1));
    tbl.push_back(mk(0,0,1,0,0,3,0,0)); tbl.push_back(mk(0,0,1,0,0,3,0,0));
    // nine back-to-back toggles into overflow
    tbl.push_back(mk(0,1,0,1,1,3,0,1)); tbl.push_back(mk(0,0,0,1,2,3,0,1));
    tbl.push_back(mk(0,1,0,1,3,3,0,1)); tbl.push_back(mk(0,0,0,1,4,3,0,1));
    tbl.push_back(mk(0,1,0,1,5,3,0,1)); tbl.push_back(mk(0,0,0,1,6,3,0,1));
    tbl.push_back(mk(0,1,0,1,7,3,0,2)); tbl.push_back(mk(0,0,0,1,7,3,1,2));
    tbl.push_back(mk(0,1,0,1,7,3,1,2));
    // clear, refill to full, then toggle+accept at full
    tbl.push_back(mk(1,1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,1,0,0,1)); tbl.push_back(mk(0,1,0,1,2,0,0,1));
    tbl.push_back(mk(0,0,0,1,3,0,0,1)); tbl.push_back(mk(0,1,0,1,4,0,0,1));
    tbl.push_back(mk(0,0,0,1,5,0,0,1)); tbl.push_back(mk(0,1,0,1,6,0,0,1));
    tbl.push_back(mk(0,0,0,1,7,0,0,2));
    tbl.push_back(mk(0,1,1,1,7,1,0,2)); tbl.push_back(mk(0,1,1,0,6,2,0,1));
    tbl.push_back(mk(0,1,1,0,5,3,0,1));
    // clear at pending=5 with a toggle in the same cycle
    tbl.push_back(mk(1,0,0,0,0,0,0,0)); tbl.push_back(mk(0,0,0,0,0,0,0,0));
    // five events then five accepts: 2-bit counter ends at 1
    tbl.push_back(mk(0,1,0,1,1,0,0,1)); tbl.push_back(mk(0,0,0,1,2,0,0,1));
    tbl.push_back(mk(0,1,0,1,3,0,0,1)); tbl.push_back(mk(0,0,0,1,4,0,0,1));
    tbl.push_back(mk(0,1,0,1,5,0,0,1));
    tbl.push_back(mk(0,1,1,0,4,1,0,1)); tbl.push_back(mk(0,1,1,0,3,2,0,1));
    tbl.push_back(mk(0,1,1,0,2,3,0,1)); tbl.push_back(mk(0,1,1,0,1,4,0,1));
    tbl.push_back(mk(0,1,1,0,0,5,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].c, tbl[i].t, tbl[i].r);
`ifndef T_FF_TOGGLE_RX_SYNC_EN
      chk($sformatf("row%0d_pulse", i), pulse_out, tbl[i].p);
      chk($sformatf("row%0d_pending", i), pending, tbl[i].pend);
      chk($sformatf("row%0d_valid", i), ev_valid, (tbl[i].pend != 0));
      chk($sformatf("row%0d_count", i), ev_count, tbl[i].cnt);
      chk($sformatf("row%0d_count2", i), cnt2, tbl[i].cnt % 4);
      chk($sformatf("row%0d_overflow", i), overflow, tbl[i].ovf);
      chk($sformatf("row%0d_state", i), state, tbl[i].st);
`endif
    end

    // 8-bit counter wrap: keep one event pending while toggling and accepting every cycle
    step(1, 0, 0);
    step(0, 1, 0);
    for (int i = 0; i < 270; i++) step(0, t_in ^ 1'b1, 1);
    step(0, t_in, 0);
    step(0, t_in, 1);
    step(0, t_in, 1);

    for (int i = 0; i < 3000; i++) begin
      logic c, t, r;
      int rp;
      rp = (i / 400) % 3;
      c = ($urandom_range(0, 99) == 0);
      t = t_in ^ ($urandom_range(0, 2) != 0);
      r = (rp == 0) ? ($urandom_range(0, 7) == 0) :
          (rp == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) != 0);
      step(c, t, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
